alu_arbiter_seq: RTL and testbench



---
 rtl/alu_arbiter_seq_pkg.sv | 26 ++
 rtl/alu_arbiter_seq_rr_arb2.sv | 36 +++
 rtl/alu_arbiter_seq.sv | 134 +++++++++++++
 tb/tb_alu_arbiter_seq.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_seq_pkg.sv
// Shared widths, ALU function codes and sequencer state encoding.
package alu_arbiter_seq_pkg;

  localparam int FUNC_W_DEF   = 3;
  localparam int DATA_W_DEF   = 4;
  localparam int RES_W_DEF    = 8;
  localparam int LOCK_MAX_DEF = 4;

  typedef enum logic [2:0] {
    F_INC   = 3'b000,
    F_ADD   = 3'b001,
    F_ADDV  = 3'b010,
    F_XOROR = 3'b011,
    F_REDOR = 3'b100,
    F_SHL   = 3'b101,
    F_SHR   = 3'b110,
    F_MUL   = 3'b111
  } alu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_seq_rr_arb2.sv
// Two-way round-robin picker. A held lock keeps the grant with the owner
// while it is requesting; if only the other side is requesting the lock breaks.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       owner_i,
  input  logic       locked_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o,
  output logic       lock_brk_o
);

  // Grant selection from (valid, owner, locked).
  always_comb begin
    gnt_vld_o  = 1'b0;
    gnt_idx_o  = owner_i;
    lock_brk_o = 1'b0;
    if (locked_i) begin
      if (valid_i[owner_i]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = owner_i;
      end else if (valid_i[~owner_i]) begin
        gnt_vld_o  = 1'b1;
        gnt_idx_o  = ~owner_i;
        lock_brk_o = 1'b1;
      end
    end else begin
      case (valid_i)
        2'b01:   begin gnt_vld_o = 1'b1; gnt_idx_o = 1'b0;     end
        2'b10:   begin gnt_vld_o = 1'b1; gnt_idx_o = 1'b1;     end
        2'b11:   begin gnt_vld_o = 1'b1; gnt_idx_o = ~owner_i; end
        default: begin gnt_vld_o = 1'b0; gnt_idx_o = owner_i;  end
      endcase
    end
  end

endmodule

// File: rtl/alu_arbiter_seq.sv
// Shares one accumulator ALU between two requesters: round-robin grant with
// an optional bounded lock, then accept -> issue -> capture per operation.
module alu_arbiter_seq
  import alu_arbiter_seq_pkg::*;
#(
  parameter int FUNC_W   = FUNC_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RES_W    = RES_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*FUNC_W-1:0] req_func,
  input  logic [2*DATA_W-1:0] req_data,
  input  logic [1:0]          req_clear,
  input  logic [1:0]          req_lock,
  output logic [1:0]          resp_valid,
  output logic [RES_W-1:0]    resp_result,
  output logic [FUNC_W-1:0]   alu_func,
  output logic [DATA_W-1:0]   alu_data,
  output logic                alu_step,
  output logic                alu_clear,
  input  logic [RES_W-1:0]    alu_acc,
  output logic                busy,
  output logic                owner
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
  localparam logic [CNT_W:0] LOCK_LIM = (CNT_W+1)'(LOCK_MAX);

  state_e              state_q, state_d;
  logic                owner_q, locked_q;
  logic [CNT_W-1:0]    lock_cnt_q;
  logic [FUNC_W-1:0]   func_q;
  logic [DATA_W-1:0]   data_q;
  logic                clear_q, lock_q;
  logic [RES_W-1:0]    result_q;
  logic                gnt_vld, gnt_idx, lock_brk;
  logic                accept;
  logic [CNT_W:0]      cnt_inc;

  rr_arb2 u_arb (
    .valid_i    (req_valid),
    .owner_i    (owner_q),
    .locked_i   (locked_q),
    .gnt_vld_o  (gnt_vld),
    .gnt_idx_o  (gnt_idx),
    .lock_brk_o (lock_brk)
  );

  assign accept  = (state_q == ST_IDLE) && gnt_vld && !reset;
  assign cnt_inc = {1'b0, lock_cnt_q} + (CNT_W+1)'(1);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: one operation takes exactly three cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (gnt_vld) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs: pulses are suppressed in the reset cycle so an aborted op leaves no trace.
  always_comb begin
    req_ready   = 2'b00;
    resp_valid  = 2'b00;
    alu_step    = 1'b0;
    alu_clear   = 1'b0;
    resp_result = result_q;
    busy        = (state_q == ST_ISSUE) || (state_q == ST_CAPTURE);
    if (!reset) begin
      case (state_q)
        ST_IDLE: if (gnt_vld) req_ready[gnt_idx] = 1'b1;
        ST_ISSUE: begin
          alu_clear = clear_q;
          alu_step  = !clear_q;
        end
        ST_CAPTURE: begin
          resp_valid[owner_q] = 1'b1;
          resp_result         = alu_acc;
        end
        default: ;
      endcase
    end
  end

  // Operation latches, ownership, lock bookkeeping and result hold register.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q    <= 1'b1;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
      func_q     <= '0;
      data_q     <= '0;
      clear_q    <= 1'b0;
      lock_q     <= 1'b0;
      result_q   <= '0;
    end else if (accept) begin
      owner_q <= gnt_idx;
      func_q  <= gnt_idx ? req_func[2*FUNC_W-1:FUNC_W] : req_func[FUNC_W-1:0];
      data_q  <= gnt_idx ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
      clear_q <= req_clear[gnt_idx];
      lock_q  <= req_lock[gnt_idx];
      if (lock_brk) begin
        locked_q   <= 1'b0;
        lock_cnt_q <= '0;
      end
    end else if (state_q == ST_CAPTURE) begin
      result_q <= alu_acc;
      if (lock_q && (cnt_inc < LOCK_LIM)) begin
        locked_q   <= 1'b1;
        lock_cnt_q <= cnt_inc[CNT_W-1:0];
      end else begin
        locked_q   <= 1'b0;
        lock_cnt_q <= '0;
      end
    end
  end

  assign alu_func = func_q;
  assign alu_data = data_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Directed and randomized bench for alu_arbiter_seq with a stub ALU and a
// transaction-level reference of the arbitration and accumulator rules.
module tb_alu_arbiter_seq;
  import alu_arbiter_seq_pkg::*;

  localparam int LM = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid, req_ready, req_clear, req_lock, resp_valid;
  logic [5:0] req_func;
  logic [7:0] req_data;
  logic [7:0] resp_result, alu_acc;
  logic [2:0] alu_func;
  logic [3:0] alu_data;
  logic       alu_step, alu_clear, busy, owner;

  always #5 clock = ~clock;

  alu_arbiter_seq #(.FUNC_W(3), .DATA_W(4), .RES_W(8), .LOCK_MAX(LM)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_data(req_data), .req_clear(req_clear), .req_lock(req_lock),
    .resp_valid(resp_valid), .resp_result(resp_result), .alu_func(alu_func),
    .alu_data(alu_data), .alu_step(alu_step), .alu_clear(alu_clear), .alu_acc(alu_acc),
    .busy(busy), .owner(owner)
  );

  function automatic logic [7:0] alu_f(logic [7:0] a, logic [2:0] f, logic [3:0] d);
    case (f)
      F_INC:   return a + 8'd1;
      F_ADD:   return a + {4'h0, d};
      F_ADDV:  return a + {4'h0, d} + 8'd1;
      F_XOROR: return a ^ {4'h0, d};
      F_REDOR: return {7'h0, |a};
      F_SHL:   return a << 1;
      F_SHR:   return a >> 1;
      default: return a * {4'h0, d};
    endcase
  endfunction

  // Stub ALU: accumulator owned by the environment, untouched by reset.
  logic [7:0] acc_q = 8'h00;
  always @(posedge clock) begin
    if (alu_clear)     acc_q <= 8'h00;
    else if (alu_step) acc_q <= alu_f(acc_q, alu_func, alu_data);
  end
  assign alu_acc = acc_q;

  // Requester drive state.
  logic       pv[2], pc[2], pl[2];
  logic [2:0] pf[2];
  logic [3:0] pd[2];
  assign req_valid = {pv[1], pv[0]};
  assign req_clear = {pc[1], pc[0]};
  assign req_lock  = {pl[1], pl[0]};
  assign req_func  = {pf[1], pf[0]};
  assign req_data  = {pd[1], pd[0]};

  // Reference model state.
  int         checks = 0, failures = 0;
  logic       m_owner, m_locked, m_g, m_clr, m_lk;
  int         m_cnt, m_busy;
  logic [2:0] m_f, m_af;
  logic [3:0] m_d, m_ad;
  logic [7:0] m_acc, m_res;
  logic       s_v, s_g, s_brk;
  logic [1:0] auto_rf = 2'b00;
  logic       auto_lk = 1'b0;
  logic       rnd = 1'b0;
  int         glog[$];
  logic [8:0] rlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pick(output logic v, output logic g, output logic brk);
    v = 1'b0; g = m_owner; brk = 1'b0;
    if (m_locked) begin
      if (pv[m_owner])       begin v = 1'b1; g = m_owner; end
      else if (pv[!m_owner]) begin v = 1'b1; g = !m_owner; brk = 1'b1; end
    end else if (pv[0] && pv[1]) begin v = 1'b1; g = !m_owner; end
    else if (pv[0]) begin v = 1'b1; g = 1'b0; end
    else if (pv[1]) begin v = 1'b1; g = 1'b1; end
  endtask

  // Compare DUT outputs with the model away from the clock edge.
  task automatic sample();
    logic [1:0] er;
    chk("ready_not_both", 32'(req_ready == 2'b11), 32'd0);
    if (reset) begin
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_step", 32'(alu_step), 32'd0);
      chk("rst_clear", 32'(alu_clear), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      return;
    end
    chk("owner", 32'(owner), 32'(m_owner));
    if (m_busy == 0) begin
      pick(s_v, s_g, s_brk);
      er = s_v ? (2'b01 << s_g) : 2'b00;
      chk("idle_ready", 32'(req_ready), 32'(er));
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_pulses", 32'({alu_step, alu_clear, resp_valid}), 32'd0);
      chk("idle_result_hold", 32'(resp_result), 32'(m_res));
      chk("idle_func_hold", 32'({alu_func, alu_data}), 32'({m_af, m_ad}));
      if (|(req_ready & req_valid)) glog.push_back(int'(req_ready[1]));
    end else if (m_busy == 2) begin
      chk("issue_busy", 32'(busy), 32'd1);
      chk("issue_ready", 32'(req_ready), 32'd0);
      chk("issue_step", 32'(alu_step), 32'(!m_clr));
      chk("issue_clear", 32'(alu_clear), 32'(m_clr));
      chk("issue_func", 32'(alu_func), 32'(m_f));
      chk("issue_data", 32'(alu_data), 32'(m_d));
      chk("issue_resp_valid", 32'(resp_valid), 32'd0);
    end else begin
      chk("cap_busy", 32'(busy), 32'd1);
      chk("cap_ready", 32'(req_ready), 32'd0);
      chk("cap_pulses", 32'({alu_step, alu_clear}), 32'd0);
      chk("cap_resp_valid", 32'(resp_valid), 32'(2'b01 << m_g));
      chk("cap_result", 32'(resp_result), 32'(m_res_next()));
      rlog.push_back({resp_valid[1], resp_result});
    end
  endtask

  function automatic logic [7:0] m_res_next();
    return m_acc;
  endfunction

  task automatic new_req(input int i, input logic [2:0] f, input logic [3:0] d,
                         input logic c, input logic l);
    pv[i] = 1'b1; pf[i] = f; pd[i] = d; pc[i] = c; pl[i] = l;
  endtask

  // Advance the model after the edge, then refresh requester inputs.
  task automatic advance();
    if (reset) begin
      m_owner = 1'b1; m_locked = 1'b0; m_cnt = 0; m_busy = 0;
      m_res = 8'h00; m_af = 3'h0; m_ad = 4'h0;
    end else if (m_busy == 0) begin
      if (s_v) begin
        m_owner = s_g;
        if (s_brk) begin m_locked = 1'b0; m_cnt = 0; end
        m_g = s_g; m_f = pf[s_g]; m_d = pd[s_g]; m_clr = pc[s_g]; m_lk = pl[s_g];
        pv[s_g] = 1'b0;
        m_busy = 2;
      end
    end else if (m_busy == 2) begin
      m_af = m_f; m_ad = m_d;
      m_acc = m_clr ? 8'h00 : alu_f(m_acc, m_f, m_d);
      m_busy = 1;
    end else begin
      m_res = m_acc;
      if (m_lk && (m_cnt + 1 < LM)) begin m_locked = 1'b1; m_cnt++; end
      else begin m_locked = 1'b0; m_cnt = 0; end
      m_busy = 0;
    end
    for (int i = 0; i < 2; i++) begin
      if (!pv[i] && auto_rf[i]) new_req(i, F_INC, 4'h0, 1'b0, auto_lk);
      if (!pv[i] && rnd && ($urandom_range(0, 2) != 0))
        new_req(i, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic tick();
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
    advance();
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n = 0;
    while ((pv[0] || pv[1] || m_busy != 0) && n < budget) begin tick(); n++; end
    checks++;
    assert (n < budget) else begin
      failures++;
      $error("FAIL timeout_%s observed=%0d cycles expected<%0d", tag, n, budget);
    end
  endtask

  task automatic run_grants(input string tag, input int cnt, input int budget);
    int n = 0;
    while (glog.size() < cnt && n < budget) begin tick(); n++; end
    checks++;
    assert (n < budget) else begin
      failures++;
      $error("FAIL timeout_%s observed=%0d grants expected=%0d", tag, glog.size(), cnt);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pc[i] = 1'b0; pl[i] = 1'b0; pf[i] = 3'h0; pd[i] = 4'h0;
    end
    m_acc = 8'h00; m_owner = 1'b1; m_locked = 1'b0; m_cnt = 0; m_busy = 0;
    m_res = 8'h00; m_af = 3'h0; m_ad = 4'h0; m_g = 1'b0; m_f = 3'h0; m_d = 4'h0;
    m_clr = 1'b0; m_lk = 1'b0; s_v = 1'b0; s_g = 1'b0; s_brk = 1'b0;
    #1;
    do_reset(2);

    // Reset values.
    @(negedge clock);
    chk("reset_owner", 32'(owner), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", 32'(resp_result), 32'd0);
    chk("reset_alu_fd", 32'({alu_func, alu_data}), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;

    // Clear then ADD 5 from requester 0.
    new_req(0, F_INC, 4'h0, 1'b1, 1'b0);
    run_idle("clear", 20);
    new_req(0, F_ADD, 4'h5, 1'b0, 1'b0);
    run_idle("add5", 20);
    chk("add5_result", 32'(rlog[rlog.size()-1]), 32'({1'b0, 8'h05}));

    // Clear, reset, then both ADD 3: req0 first, then req1.
    new_req(0, F_INC, 4'h0, 1'b1, 1'b0);
    run_idle("clear2", 20);
    do_reset(1);
    rlog.delete(); glog.delete();
    new_req(0, F_ADD, 4'h3, 1'b0, 1'b0);
    new_req(1, F_ADD, 4'h3, 1'b0, 1'b0);
    run_idle("both_add3", 30);
    chk("rr_first", 32'(rlog[0]), 32'({1'b0, 8'h03}));
    chk("rr_second", 32'(rlog[1]), 32'({1'b1, 8'h06}));

    // req1 locks with repeated INC while req0 waits: four req1 ops, then req0.
    glog.delete();
    auto_lk = 1'b1; auto_rf = 2'b10;
    new_req(1, F_INC, 4'h0, 1'b0, 1'b1);
    run_grants("lock_first", 1, 20);
    new_req(0, F_INC, 4'h0, 1'b0, 1'b0);
    run_grants("lock_run", 5, 60);
    auto_rf = 2'b00; auto_lk = 1'b0;
    run_idle("lock_drain", 40);
    chk("lock_g0", 32'(glog[0]), 32'd1);
    chk("lock_g3", 32'(glog[3]), 32'd1);
    chk("lock_g4", 32'(glog[4]), 32'd0);

    // req0 holds a lock then drops valid: req1 wins and the lock is broken.
    glog.delete();
    new_req(0, F_ADD, 4'h1, 1'b0, 1'b1);
    run_idle("lk0", 20);
    new_req(1, F_ADD, 4'h2, 1'b0, 1'b0);
    run_idle("brk1", 20);
    new_req(0, F_ADD, 4'h1, 1'b0, 1'b0);
    new_req(1, F_ADD, 4'h1, 1'b0, 1'b0);
    run_idle("after_brk", 30);
    chk("brk_g1", 32'(glog[1]), 32'd1);
    chk("brk_g2", 32'(glog[2]), 32'd0);

    // Reset while in ISSUE: no pulses, everything back to reset values.
    new_req(0, F_ADD, 4'h7, 1'b0, 1'b0);
    begin
      int n = 0;
      while (m_busy != 2 && n < 20) begin tick(); n++; end
    end
    chk("reached_issue", 32'(m_busy), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_owner", 32'(owner), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_outs", 32'({resp_valid, resp_result, alu_func, alu_data}), 32'd0);
    chk("midrst_acc_untouched", 32'(alu_acc), 32'(m_acc));
    @(posedge clock); #1;

    // acc=3 then MUL 4 gives 0x0C.
    new_req(0, F_INC, 4'h0, 1'b1, 1'b0);
    run_idle("clr3", 20);
    for (int k = 0; k < 3; k++) begin
      new_req(0, F_INC, 4'h0, 1'b0, 1'b0);
      run_idle("inc", 20);
    end
    new_req(0, F_MUL, 4'h4, 1'b0, 1'b0);
    run_idle("mul", 20);
    chk("mul_result", 32'(rlog[rlog.size()-1]), 32'({1'b0, 8'h0C}));

    // Randomized traffic against the model.
    rnd = 1'b1;
    for (int k = 0; k < 600; k++) tick();
    rnd = 1'b0;
    run_idle("rand_drain", 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
